// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache (read-only) and the dcache (read/write).
// The grant is registered with data priority, an instruction starvation guard and an abort path.
module mem_arbiter #(
   parameter int unsigned MAXWAIT = 8,
   parameter int unsigned WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              merr
);

   typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [7:0] STARVE_MAX = 8'(MAXWAIT);

   state_t     state_q, state_d;
   logic [7:0] starve_q, starve_d;
   logic       ram_done;

   assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      merr     = 1'b0;
      case (state_q)
         IDLE: begin
            // A starved icache overrides the normal data priority.
            if ((starve_q == STARVE_MAX) && iREN) begin
               state_d = IGNT;
            end else if (dREN || dWEN) begin
               state_d = DGNT;
            end else if (iREN) begin
               state_d = IGNT;
            end
         end
         DGNT: begin
            if (!dREN && !dWEN) begin
               state_d = IDLE;
            end else begin
               ramREN   = dREN;
               ramWEN   = dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ram_done) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  merr    = (ramstate == RAM_ERROR);
                  state_d = IDLE;
               end
            end
         end
         IGNT: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ram_done) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  merr    = (ramstate == RAM_ERROR);
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter: counts cycles the icache waits outside its grant.
   always_comb begin
      if (!iREN) begin
         starve_d = '0;
      end else if ((state_q != IGNT) && (state_d == IGNT)) begin
         starve_d = '0;
      end else if ((state_q != IGNT) && (starve_q < STARVE_MAX)) begin
         starve_d = starve_q + 8'd1;
      end else begin
         starve_d = starve_q;
      end
   end

endmodule
